// File: rtl/idli_sqi_ctrl_m.sv
// Nibble-serial quad SQI SRAM controller: issues READ/WRITE commands and streams
// 16b words as four nibbles, least-significant nibble first, with auto-increment bursts.
module idli_sqi_ctrl_m (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_req,
  input  logic        i_sqi_wr,
  input  logic [15:0] i_sqi_addr,
  input  logic [3:0]  i_sqi_wdata,
  output logic        o_sqi_wready,
  output logic [3:0]  o_sqi_rdata,
  output logic        o_sqi_rvalid,
  output logic        o_sqi_busy,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DUMMY = 3'd3,
    S_DATA  = 3'd4,
    S_END   = 3'd5
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_wr;
  logic        w_wr_nxt;
  logic [15:0] r_addr;
  logic [15:0] w_addr_nxt;
  logic        r_cs_n;
  logic        r_sck_en;
  logic        r_oe;
  logic        r_busy;
  logic        w_cs_n_nxt;
  logic        w_oe_nxt;
  logic [7:0]  w_cmd;
  logic [23:0] w_baddr;
  logic [3:0]  w_sio;
  logic        w_rd_data;
  logic        w_wr_data;

  // Pick one nibble of the 24b byte address, most-significant nibble at index 0.
  function automatic logic [3:0] addr_nibble(input logic [23:0] baddr, input logic [2:0] idx);
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = baddr[23:20];
      3'd1:    nib = baddr[19:16];
      3'd2:    nib = baddr[15:12];
      3'd3:    nib = baddr[11:8];
      3'd4:    nib = baddr[7:4];
      3'd5:    nib = baddr[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  // Next-state, nibble counter and request latching.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_nxt    = r_wr;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (i_sqi_req) begin
          w_wr_nxt    = i_sqi_wr;
          w_addr_nxt  = i_sqi_addr;
          w_state_nxt = S_CMD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CMD: begin
        if (r_cnt == 3'd1) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_ADDR;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_ADDR: begin
        if (r_cnt == 3'd5) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = r_wr ? S_DATA : S_DUMMY;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DUMMY: begin
        if (r_cnt == 3'd1) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DATA: begin
        // The burst only continues if req is high on the last nibble of the word.
        if (r_cnt == 3'd3) begin
          w_cnt_nxt   = 3'd0;
          w_state_nxt = i_sqi_req ? S_DATA : S_END;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_END: begin
        w_cnt_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pin controls are decoded from the next state so they come straight from flops.
  always_comb begin
    w_cs_n_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_END);
    case (w_state_nxt)
      S_CMD:   w_oe_nxt = 1'b1;
      S_ADDR:  w_oe_nxt = 1'b1;
      S_DATA:  w_oe_nxt = w_wr_nxt;
      default: w_oe_nxt = 1'b0;
    endcase
  end

  // State, counter, latched request and registered pin controls.
  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_wr     <= 1'b0;
      r_addr   <= 16'h0000;
      r_cs_n   <= 1'b1;
      r_sck_en <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wr     <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_cs_n   <= w_cs_n_nxt;
      r_sck_en <= ~w_cs_n_nxt;
      r_oe     <= w_oe_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign w_cmd     = r_wr ? CMD_WRITE : CMD_READ;
  assign w_baddr   = {7'b0000000, r_addr, 1'b0};
  assign w_rd_data = (r_state == S_DATA) && !r_wr;
  assign w_wr_data = (r_state == S_DATA) && r_wr;

  // SIO output mux; write data passes straight through so ALU results need no buffering.
  always_comb begin
    case (r_state)
      S_CMD:   w_sio = (r_cnt == 3'd0) ? w_cmd[7:4] : w_cmd[3:0];
      S_ADDR:  w_sio = addr_nibble(w_baddr, r_cnt);
      S_DATA:  w_sio = r_wr ? i_sqi_wdata : 4'h0;
      default: w_sio = 4'h0;
    endcase
  end

  assign o_sqi_sio    = w_sio;
  assign o_sqi_sio_oe = r_oe;
  assign o_sqi_cs_n   = r_cs_n;
  assign o_sqi_sck_en = r_sck_en;
  assign o_sqi_busy   = r_busy;
  assign o_sqi_rvalid = w_rd_data;
  assign o_sqi_rdata  = w_rd_data ? i_sqi_sio : 4'h0;
  assign o_sqi_wready = w_wr_data;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: a cycle-indexed transaction model plus literal pins.
module tb_idli_sqi_ctrl_m;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [3:0]  wdata;
  logic        wready;
  logic [3:0]  rdata;
  logic        rvalid;
  logic        busy;
  logic        cs_n;
  logic        sck_en;
  logic [3:0]  sio_o;
  logic        sio_oe;
  logic [3:0]  sio_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       cs_n;
    logic       oe;
    logic       busy;
    logic       rvalid;
    logic       wready;
    logic       sio_chk;
    logic [3:0] sio;
    logic [3:0] rdata;
  } exp_t;

  exp_t       cur_e;
  int         cur_t;
  logic       chk_en = 1'b0;
  logic [3:0] cap_sio   [0:63];
  logic [3:0] cap_rdata [0:63];
  logic       cap_csn   [0:63];
  logic       cap_rv    [0:63];

  idli_sqi_ctrl_m dut (
    .i_sqi_gck    (clk),
    .i_sqi_rst    (rst),
    .i_sqi_req    (req),
    .i_sqi_wr     (wr),
    .i_sqi_addr   (addr),
    .i_sqi_wdata  (wdata),
    .o_sqi_wready (wready),
    .o_sqi_rdata  (rdata),
    .o_sqi_rvalid (rvalid),
    .o_sqi_busy   (busy),
    .o_sqi_cs_n   (cs_n),
    .o_sqi_sck_en (sck_en),
    .o_sqi_sio    (sio_o),
    .o_sqi_sio_oe (sio_oe),
    .i_sqi_sio    (sio_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %h expected %h", name, cur_t, act, exp);
    end
  endtask

  // What the pins must show at cycle t of a transaction started at cycle 0.
  function automatic exp_t model(input int t, input bit w, input logic [15:0] a,
                                 input int nw, input logic [63:0] words);
    exp_t e;
    int ds, de, ec, k, wi, idx;
    logic [7:0]  cmd;
    logic [31:0] ba;
    logic [3:0]  nib;
    e = '0;
    e.cs_n = 1'b1;
    ds = w ? 9 : 11;
    de = ds + 4 * nw - 1;
    ec = de + 1;
    cmd = w ? 8'h02 : 8'h03;
    ba = {16'h0000, a} * 32'd2;
    if (t >= 1 && t < ec) begin
      e.cs_n = 1'b0;
      e.busy = 1'b1;
    end
    if (t == ec) e.busy = 1'b1;
    if (t >= 1 && t <= 2) begin
      e.oe = 1'b1; e.sio_chk = 1'b1;
      e.sio = (t == 1) ? cmd[7:4] : cmd[3:0];
    end else if (t >= 3 && t <= 8) begin
      k = t - 3;
      e.oe = 1'b1; e.sio_chk = 1'b1;
      e.sio = 4'((ba >> (4 * (5 - k))) & 32'hF);
    end else if (t >= ds && t <= de) begin
      wi  = (t - ds) / 4;
      idx = (t - ds) % 4;
      nib = 4'((words >> (16 * wi + 4 * idx)) & 64'hF);
      if (w) begin
        e.oe = 1'b1; e.wready = 1'b1; e.sio_chk = 1'b1; e.sio = nib;
      end else begin
        e.rvalid = 1'b1; e.rdata = nib;
      end
    end
    return e;
  endfunction

  // Single compare process: every cycle the driver marks as meaningful is checked here.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cs_n",   {15'd0, cs_n},   {15'd0, cur_e.cs_n});
      chk("sck_en", {15'd0, sck_en}, {15'd0, ~cur_e.cs_n});
      chk("oe",     {15'd0, sio_oe}, {15'd0, cur_e.oe});
      chk("busy",   {15'd0, busy},   {15'd0, cur_e.busy});
      chk("rvalid", {15'd0, rvalid}, {15'd0, cur_e.rvalid});
      chk("wready", {15'd0, wready}, {15'd0, cur_e.wready});
      if (cur_e.sio_chk) chk("sio", {12'd0, sio_o}, {12'd0, cur_e.sio});
      if (cur_e.rvalid) chk("rdata", {12'd0, rdata}, {12'd0, cur_e.rdata});
      if (cur_t < 64) begin
        cap_sio[cur_t]   = sio_o;
        cap_rdata[cur_t] = rdata;
        cap_csn[cur_t]   = cs_n;
        cap_rv[cur_t]    = rvalid;
      end
    end
  end

  task automatic reset_chk(input string tag);
    chk({tag, "_cs_n"},   {15'd0, cs_n},   16'd1);
    chk({tag, "_sck_en"}, {15'd0, sck_en}, 16'd0);
    chk({tag, "_oe"},     {15'd0, sio_oe}, 16'd0);
    chk({tag, "_sio"},    {12'd0, sio_o},  16'd0);
    chk({tag, "_busy"},   {15'd0, busy},   16'd0);
    chk({tag, "_rvalid"}, {15'd0, rvalid}, 16'd0);
    chk({tag, "_wready"}, {15'd0, wready}, 16'd0);
  endtask

  // Drive one transaction; toggle scrambles req where it must be ignored, abort_t fires reset.
  task automatic run_txn(input bit w, input logic [15:0] a, input int nw,
                         input logic [63:0] words, input bit toggle, input int abort_t);
    int ds, de, ec, idx, wi;
    exp_t e;
    ds = w ? 9 : 11;
    de = ds + 4 * nw - 1;
    ec = de + 1;
    for (int t = 0; t <= ec + 2; t++) begin
      @(posedge clk);
      #1;
      e = model(t, w, a, nw, words);
      cur_t = t;
      cur_e = e;
      if (t == 0) begin
        req = 1'b1; wr = w; addr = a;
      end else begin
        wr = 1'($urandom); addr = 16'($urandom);
        if (t >= ds && t <= de) begin
          idx = (t - ds) % 4;
          wi  = (t - ds) / 4;
          if (idx == 3) req = (wi < nw - 1);
          else if (toggle) req = 1'($urandom);
          else req = 1'b1;
        end else if (t < ds) begin
          req = toggle ? 1'($urandom) : 1'b1;
        end else if (t == ec) begin
          req = toggle;
        end else begin
          req = 1'b0;
        end
      end
      wdata = e.wready ? e.sio : 4'($urandom);
      sio_i = e.rvalid ? e.rdata : 4'($urandom);
      if (t == abort_t) begin
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1 reset_chk("abort");
        @(posedge clk);
        #1 reset_chk("abort_hold");
        req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      chk_en = 1'b1;
    end
    @(posedge clk);
    #1 chk_en = 1'b0;
    req = 1'b0;
  endtask

  logic [3:0] lit_rd [0:7];
  logic [3:0] lit_wr [0:11];
  int         rv_cnt;

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 4'h0; sio_i = 4'h0;
    cur_t = 0; cur_e = '0;
    #2 reset_chk("por");
    @(posedge clk);
    #3 reset_chk("por_clk");
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read of 16'h0FA5 from 16'h1234, then literal pins on the captured trace.
    run_txn(1'b0, 16'h1234, 1, 64'h0FA5, 1'b0, -1);
    lit_rd[0] = 4'h0; lit_rd[1] = 4'h3; lit_rd[2] = 4'h0; lit_rd[3] = 4'h0;
    lit_rd[4] = 4'h2; lit_rd[5] = 4'h4; lit_rd[6] = 4'h6; lit_rd[7] = 4'h8;
    for (int i = 0; i < 8; i++) chk("lit_rd_sio", {12'd0, cap_sio[i + 1]}, {12'd0, lit_rd[i]});
    chk("lit_rd_word", {cap_rdata[14], cap_rdata[13], cap_rdata[12], cap_rdata[11]}, 16'h0FA5);
    chk("lit_rd_csn14", {15'd0, cap_csn[14]}, 16'd0);
    chk("lit_rd_csn15", {15'd0, cap_csn[15]}, 16'd1);

    // Single write of 16'hBEEF to 16'hFFFF.
    run_txn(1'b1, 16'hFFFF, 1, 64'hBEEF, 1'b0, -1);
    lit_wr[0] = 4'h0; lit_wr[1] = 4'h2; lit_wr[2]  = 4'h0; lit_wr[3]  = 4'h1;
    lit_wr[4] = 4'hF; lit_wr[5] = 4'hF; lit_wr[6]  = 4'hF; lit_wr[7]  = 4'hE;
    lit_wr[8] = 4'hF; lit_wr[9] = 4'hE; lit_wr[10] = 4'hE; lit_wr[11] = 4'hB;
    for (int i = 0; i < 12; i++) chk("lit_wr_sio", {12'd0, cap_sio[i + 1]}, {12'd0, lit_wr[i]});
    chk("lit_wr_csn13", {15'd0, cap_csn[13]}, 16'd1);

    // Three-word burst read with req held high.
    run_txn(1'b0, 16'h0010, 3, 64'h09BD_7E52_C3A1, 1'b0, -1);
    rv_cnt = 0;
    for (int i = 0; i < 30; i++) rv_cnt += int'(cap_rv[i]);
    chk("lit_burst_rvalid_cycles", 16'(rv_cnt), 16'd12);

    // req scrambled outside the index-3 samples, and high during END.
    run_txn(1'b1, 16'h8001, 2, 64'h5A5A_1234, 1'b1, -1);
    run_txn(1'b0, 16'h4321, 2, 64'hDEAD_0F0F, 1'b1, -1);

    // Reset at write data index 2, then a clean read.
    run_txn(1'b1, 16'h0042, 2, 64'h7777_ABCD, 1'b0, 11);
    run_txn(1'b0, 16'h0042, 1, 64'h3C96, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
